hazard_ctrl_mc: RTL and testbench

//  Multi-cycle hazard controller for the 5-stage pipeline. Tracks outstanding loads in a per-register

---
 rtl/hazard_pkg.sv | 9 +
 rtl/hazard_scoreboard.sv | 33 +++
 rtl/hazard_ctrl_mc.sv | 90 +++++++++
 tb/tb_hazard_ctrl_mc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the multi-cycle hazard controller.
package hazard_pkg;
  localparam int PERF_W = 32;
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, FLUSH} state_e;
  typedef enum logic [2:0] {M_RUN, M_LU, M_MW, M_BR, M_FL} mode_e;
  function automatic int lat_w(input int lat);
    return $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register load countdown with set, clear-all, freeze and two busy read ports.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int RAW = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set_i,
  input  logic [RAW-1:0] set_id_i,
  input  logic           clr_i,
  input  logic           freeze_i,
  input  logic [RAW-1:0] rd_a_i,
  input  logic [RAW-1:0] rd_b_i,
  output logic           busy_a_o,
  output logic           busy_b_o
);
  localparam int N = 2 ** RAW;
  localparam int LW = lat_w(LOAD_LAT);
  logic [LW-1:0] cnt_q [N];
  logic [LW-1:0] cnt_d [N];
  always_comb begin
    for (int i = 0; i < N; i++)
      cnt_d[i] = clr_i ? '0 :
                 freeze_i ? cnt_q[i] :
                 (set_i && set_id_i == RAW'(i)) ? LW'(LOAD_LAT) :
                 (cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    else cnt_q <= cnt_d;
  assign busy_a_o = cnt_q[rd_a_i] != '0;
  assign busy_b_o = cnt_q[rd_b_i] != '0;
endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: load-use stall, memory-wait freeze and multi-cycle branch flush sequencing.
// Defining HAZARD_PERF_EN adds saturating perf counters for stalls, redirects and memory waits.
module hazard_ctrl_mc import hazard_pkg::*; #(
  parameter int RAW = 5,
  parameter int LOAD_LAT = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_br_cnt,
  output logic [PERF_W-1:0] perf_mw_cnt,
`endif
  input  logic              id_valid,
  input  logic [RAW-1:0]    id_rs_id,
  input  logic              id_uses_rs,
  input  logic [RAW-1:0]    id_rt_id,
  input  logic              id_uses_rt,
  input  logic [RAW-1:0]    id_rdst_id,
  input  logic              id_is_load,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              EX_MEM_flush,
  output logic              pipe_hold,
  output logic              stall_o
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  state_e        state_q, state_d;
  logic [FW-1:0] flush_q, flush_d;
  mode_e         mode;
  logic          busy_rs, busy_rt, hazard, in_flush, issue;
  hazard_scoreboard #(.RAW(RAW), .LOAD_LAT(LOAD_LAT)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_i    (issue && id_is_load && id_rdst_id != '0),
    .set_id_i (id_rdst_id),
    .clr_i    (mode == M_BR),
    .freeze_i (mem_busy),
    .rd_a_i   (id_rs_id),
    .rd_b_i   (id_rt_id),
    .busy_a_o (busy_rs),
    .busy_b_o (busy_rt)
  );
  assign hazard = id_valid && ((id_uses_rs && id_rs_id != '0 && busy_rs) ||
                               (id_uses_rt && id_rt_id != '0 && busy_rt));
  // A wait that interrupted a flush resumes it once memory is ready again.
  assign in_flush = state_q == FLUSH || (state_q == MEM_WAIT && flush_q != '0);
  assign mode = mem_busy ? M_MW : branch_taken ? M_BR : in_flush ? M_FL : hazard ? M_LU : M_RUN;
  assign issue = id_valid && (mode == M_RUN || mode == M_FL);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  always_comb begin
    state_d = mode == M_MW ? MEM_WAIT :
              mode == M_LU ? LU_STALL :
              ((mode == M_BR && FLUSH_CYC > 1) || (mode == M_FL && flush_q != FW'(1))) ? FLUSH : RUN;
    flush_d = mode == M_BR ? FW'(FLUSH_CYC - 1) : mode == M_FL ? flush_q - 1'b1 : flush_q;
  end
  always_comb begin
    pc_write     = !rst && (mode == M_RUN || mode == M_BR || mode == M_FL);
    IF_ID_write  = !rst && (mode == M_RUN || mode == M_BR || mode == M_FL);
    IF_ID_flush  = rst || mode == M_BR || mode == M_FL;
    ID_EX_flush  = rst || mode == M_BR || mode == M_LU;
    EX_MEM_flush = rst || mode == M_BR;
    pipe_hold    = !rst && mode == M_MW;
    stall_o      = !rst && mode == M_LU;
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_lu_cnt <= '0;
      perf_br_cnt <= '0;
      perf_mw_cnt <= '0;
    end else begin
      perf_lu_cnt <= perf_lu_cnt + PERF_W'(mode == M_LU && perf_lu_cnt != '1);
      perf_br_cnt <= perf_br_cnt + PERF_W'(mode == M_BR && perf_br_cnt != '1);
      perf_mw_cnt <= perf_mw_cnt + PERF_W'(mode == M_MW && perf_mw_cnt != '1);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: directed scenarios plus random traffic checked against a pending-load model.
module tb_hazard_ctrl_mc;
  localparam int RAW = 5, LL = 2, FC = 2;
  localparam logic [6:0] RST_OUT = 7'b0011100;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_is_load = 0, branch_taken = 0, mem_busy = 0;
  logic [RAW-1:0] id_rs_id = '0, id_rt_id = '0, id_rdst_id = '0;
  logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold, stall_o;
  int n_chk = 0, n_fail = 0;
  int pend [32];
  int fl = 0;
  logic last_stall;
  logic [6:0] last_out;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.RAW(RAW), .LOAD_LAT(LL), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_id(id_rs_id), .id_uses_rs(id_uses_rs),
    .id_rt_id(id_rt_id), .id_uses_rt(id_uses_rt), .id_rdst_id(id_rdst_id), .id_is_load(id_is_load),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .pipe_hold(pipe_hold), .stall_o(stall_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush, pipe_hold, stall_o};
  endfunction

  function automatic logic haz();
    return id_valid && ((id_uses_rs && id_rs_id != 0 && pend[id_rs_id] > 0) ||
                        (id_uses_rt && id_rt_id != 0 && pend[id_rt_id] > 0));
  endfunction

  // Expected {pc, ifw, if_id_fl, id_ex_fl, ex_mem_fl, hold, stall} from the priority rules.
  function automatic logic [6:0] expect_out();
    if (rst) return RST_OUT;
    if (mem_busy) return 7'b0000010;
    if (branch_taken) return 7'b1111100;
    if (fl > 0) return 7'b1110000;
    if (haz()) return 7'b0001001;
    return 7'b1100000;
  endfunction

  task automatic model_clear();
    foreach (pend[i]) pend[i] = 0;
    fl = 0;
  endtask

  task automatic advance();
    logic h, iss;
    h = haz();
    iss = id_valid && (fl > 0 || !h);
    if (rst) model_clear();
    else if (mem_busy) begin end
    else if (branch_taken) begin
      foreach (pend[i]) pend[i] = 0;
      fl = FC - 1;
    end else begin
      foreach (pend[i]) if (pend[i] > 0) pend[i]--;
      if (fl > 0) fl--;
      if (iss && id_is_load && id_rdst_id != 0) pend[id_rdst_id] = LL;
    end
  endtask

  task automatic cyc(input string tag, input bit v, input int rs, input bit urs, input int rt,
                     input bit urt, input int rd, input bit ld, input bit br, input bit mb);
    id_valid = v; id_rs_id = 5'(rs); id_uses_rs = urs; id_rt_id = 5'(rt); id_uses_rt = urt;
    id_rdst_id = 5'(rd); id_is_load = ld; branch_taken = br; mem_busy = mb;
    #4;
    last_out = outs();
    last_stall = stall_o;
    chk(tag, last_out, expect_out());
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic do_rst(input string tag);
    rst = 1'b1;
    #4;
    chk(tag, outs(), RST_OUT);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Presents a consumer of reg r until it issues; returns the number of bubbles seen.
  task automatic count_bubbles(input string tag, input int r, input bit on_rt, output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(tag, 1, on_rt ? 0 : r, !on_rt, on_rt ? r : 0, on_rt, 1, 0, 0, 0);
      if (!last_stall) break;
      n++;
    end
  endtask

  initial begin
    int n;
    model_clear();
    #1;
    chk("reset", outs(), RST_OUT);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    cyc("lw5", 1, 0, 0, 0, 0, 5, 1, 0, 0);
    count_bubbles("use5", 5, 1, n);
    chk("b2b_bubbles", n, LL);
    cyc("lw5b", 1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc("or7", 1, 1, 1, 2, 1, 7, 0, 0, 0);
    count_bubbles("use5b", 5, 1, n);
    chk("gap_bubbles", n, LL - 1);
    cyc("lw0", 1, 0, 0, 0, 0, 0, 1, 0, 0);
    count_bubbles("use0", 0, 0, n);
    chk("r0_bubbles", n, 0);
    cyc("lw6", 1, 0, 0, 0, 0, 6, 1, 0, 0);
    cyc("nors6", 1, 6, 0, 0, 0, 1, 0, 0, 0);
    chk("nors_stall", last_stall, 0);
    idle(3);
    cyc("lw3", 1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc("br", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("br_c0", last_out, 7'b1111100);
    cyc("fl1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_c1", last_out, 7'b1110000);
    count_bubbles("use3", 3, 0, n);
    chk("br_clr_bubbles", n, 0);
    cyc("lw4", 1, 0, 0, 0, 0, 4, 1, 0, 0);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      cyc("mw", 1, 4, 1, 0, 0, 1, 0, 0, 1);
      n += int'(last_out[1]);
    end
    chk("mw_holds", n, 3);
    count_bubbles("use4", 4, 0, n);
    chk("mw_bubbles", n, LL);
    cyc("lw9", 1, 0, 0, 0, 0, 9, 1, 0, 0);
    cyc("use9", 1, 9, 1, 0, 0, 1, 0, 0, 0);
    chk("lu_before_rst", last_stall, 1);
    do_rst("rst_in_lu");
    count_bubbles("use9r", 9, 0, n);
    chk("rst_sb_clear", n, 0);
    cyc("br2", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_rst("rst_in_fl");
    cyc("after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_run", last_out, 7'b1100000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) do_rst("rand_rst");
      else cyc("rand", $urandom_range(9) < 8, $urandom_range(3), $urandom_range(1), $urandom_range(3),
               $urandom_range(1), $urandom_range(3), $urandom_range(2) == 0,
               $urandom_range(9) == 0, $urandom_range(99) < 15);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
